mmio_mem_target: RTL and testbench



---
 rtl/mmio_mem_target.sv | 166 ++++++++++++++++
 tb/tb_mmio_mem_target.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_mem_target.sv
// MMIO memory target: byte-masked word array behind a fixed-latency pipeline and
// an in-order response FIFO that absorbs requester backpressure.
module mmio_mem_target #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 22,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_wbe,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic                    req_rsp_ready,
    output logic                    rsp_ready,
    output logic                    rsp_ack,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_error
);

    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = ADDR_WIDTH - OFF;
    localparam int IW1 = IW + 1;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]         word_idx_s;
    logic [MW-1:0]         mem_idx_s;
    logic                  in_range_s;
    logic                  accept_s;
    logic                  retire_s;
    logic                  push_s;
    logic                  unused_low_s;

    logic [CW-1:0]         outstanding_r;

    logic [LATENCY-1:0]    pipe_valid_r;
    logic [LATENCY-1:0]    pipe_err_r;
    logic [DATA_WIDTH-1:0] pipe_data_r [LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data_r [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         fifo_count_r;

    // Sub-word address bits only select bytes within a word, which the strobes already cover.
    assign unused_low_s = ^req_addr[OFF-1:0];
    assign word_idx_s   = req_addr[ADDR_WIDTH-1:OFF];
    assign mem_idx_s    = word_idx_s[MW-1:0];
    assign in_range_s   = ({1'b0, word_idx_s} < IW1'(DEPTH));

    // Pipeline and FIFO entries all count as outstanding, so the FIFO can never overflow.
    assign rsp_ready = ~rst & (outstanding_r < CW'(RSP_DEPTH));
    assign accept_s  = req_valid & rsp_ready;
    assign rsp_ack   = accept_s;
    assign rsp_valid = (fifo_count_r != '0);
    assign retire_s  = rsp_valid & req_rsp_ready;
    assign push_s    = pipe_valid_r[LATENCY-1];

    // Byte-masked array write on an accepted in-range write.
    always_ff @(posedge clk) begin
        if (accept_s && req_we && in_range_s) begin
            for (int b = 0; b < BW; b++) begin
                if (req_wbe[b]) begin
                    mem[mem_idx_s][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // Outstanding request counter: accept adds, retire removes.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, retire_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Latency pipeline control bits; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_r <= '0;
            pipe_err_r   <= '0;
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_err_r[0]   <= accept_s & ~in_range_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
            end
        end
    end

    // Latency pipeline payload; read data is captured at the accept edge and qualified by valid.
    always_ff @(posedge clk) begin
        if (accept_s && !req_we && in_range_s) begin
            pipe_data_r[0] <= mem[mem_idx_s];
        end else begin
            pipe_data_r[0] <= '0;
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data_r[i] <= pipe_data_r[i-1];
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= pipe_data_r[LATENCY-1];
            fifo_err_r[wr_ptr_r]  <= pipe_err_r[LATENCY-1];
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (retire_s) begin
                rd_ptr_r <= (rd_ptr_r == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, retire_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Head of FIFO drives the response; zeros whenever nothing is pending.
    always_comb begin
        rsp_data  = '0;
        rsp_error = 1'b0;
        if (rsp_valid) begin
            rsp_data  = fifo_data_r[rd_ptr_r];
            rsp_error = fifo_err_r[rd_ptr_r];
        end else begin
            rsp_data  = '0;
            rsp_error = 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_mem_target.sv
// Directed self-checking bench for mmio_mem_target (LATENCY=2, RSP_DEPTH=4, DEPTH=1024).
module tb_mmio_mem_target;

    localparam int DW = 512;
    localparam int AW = 22;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_we = 1'b0;
    logic [BW-1:0] req_wbe = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_rsp_ready = 1'b0;
    logic          rsp_ready;
    logic          rsp_ack;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] a5;
    logic [DW-1:0] ones;
    logic [DW-1:0] p0;
    logic [DW-1:0] exp1;
    logic [DW-1:0] w2;
    logic [DW-1:0] top;

    mmio_mem_target #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .LATENCY(2), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
        .req_wbe(req_wbe), .req_data(req_data), .req_rsp_ready(req_rsp_ready),
        .rsp_ready(rsp_ready), .rsp_ack(rsp_ack), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [AW-1:0] addr,
                             input logic [BW-1:0] wbe, input logic [DW-1:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wbe   = wbe;
        req_data  = data;
    endtask

    // Idle bus carries junk aimed at word 1 to show req_* is ignored without req_valid.
    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_addr  = 22'h000040;
        req_wbe   = '1;
        req_data  = {16{$urandom()}};
    endtask

    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wbe,
                           input logic [DW-1:0] data, output logic ack, output int lat,
                           output logic [DW-1:0] rd, output logic err);
        tick();
        drive_req(we, addr, wbe, data);
        #1;
        ack = rsp_ack;
        tick();
        idle();
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd  = rsp_data;
        err = rsp_error;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_req(1'b1, 22'h000000, '1, ones);
        tick();
        tick();
        #1;
        checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", rsp_ready); end
        checks++; if (rsp_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b expected 0", rsp_ack); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", rsp_error); end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", rsp_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_write_read();
        logic ack; int lat; logic [DW-1:0] rd; logic err;
        req_rsp_ready = 1'b1;
        run_txn(1'b1, 22'h000040, '1, a5, ack, lat, rd, err);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack: got %b expected 1", ack); end
        checks++; if (lat != 2) begin failures++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (rd !== '0 || err !== 1'b0) begin failures++; $display("FAIL wr_rsp: got err=%b data=%h expected err=0 data=0", err, rd); end
        run_txn(1'b0, 22'h000040, '0, '0, ack, lat, rd, err);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_ack: got %b expected 1", ack); end
        checks++; if (lat != 2) begin failures++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== a5 || err !== 1'b0) begin failures++; $display("FAIL rd_data: got err=%b data=%h expected err=0 data=%h", err, rd, a5); end
    endtask

    task automatic test_partial_strobe();
        logic ack; int lat; logic [DW-1:0] rd; logic err;
        run_txn(1'b1, 22'h000040, '1, '0, ack, lat, rd, err);
        run_txn(1'b1, 22'h000040, 64'h3, ones, ack, lat, rd, err);
        checks++; if (err !== 1'b0 || rd !== '0) begin failures++; $display("FAIL strobe_wr_rsp: got err=%b data=%h expected err=0 data=0", err, rd); end
        run_txn(1'b0, 22'h000040, '0, '0, ack, lat, rd, err);
        checks++; if (rd !== exp1) begin failures++; $display("FAIL strobe_rd: got %h expected %h", rd, exp1); end
        run_txn(1'b1, 22'h000043, '0, ones, ack, lat, rd, err);
        checks++; if (ack !== 1'b1 || err !== 1'b0 || rd !== '0) begin failures++; $display("FAIL wbe0_rsp: got ack=%b err=%b data=%h expected ack=1 err=0 data=0", ack, err, rd); end
        run_txn(1'b0, 22'h00007F, '0, '0, ack, lat, rd, err);
        checks++; if (rd !== exp1) begin failures++; $display("FAIL wbe0_unchanged: got %h expected %h", rd, exp1); end
    endtask

    task automatic test_out_of_range();
        logic ack; int lat; logic [DW-1:0] rd; logic err;
        run_txn(1'b1, 22'h000000, '1, p0, ack, lat, rd, err);
        run_txn(1'b1, 22'h010000, '1, ones, ack, lat, rd, err);
        checks++; if (ack !== 1'b1 || err !== 1'b1 || rd !== '0) begin failures++; $display("FAIL oob_wr: got ack=%b err=%b data=%h expected ack=1 err=1 data=0", ack, err, rd); end
        run_txn(1'b0, 22'h010000, '0, '0, ack, lat, rd, err);
        checks++; if (err !== 1'b1 || rd !== '0 || lat != 2) begin failures++; $display("FAIL oob_rd: got err=%b lat=%0d data=%h expected err=1 lat=2 data=0", err, lat, rd); end
        run_txn(1'b0, 22'h00003F, '0, '0, ack, lat, rd, err);
        checks++; if (err !== 1'b0 || rd !== p0) begin failures++; $display("FAIL oob_word0: got err=%b data=%h expected err=0 data=%h", err, rd, p0); end
        run_txn(1'b1, 22'h00FFC0, '1, top, ack, lat, rd, err);
        run_txn(1'b0, 22'h00FFC0, '0, '0, ack, lat, rd, err);
        checks++; if (err !== 1'b0 || rd !== top) begin failures++; $display("FAIL last_word: got err=%b data=%h expected err=0 data=%h", err, rd, top); end
    endtask

    task automatic test_back_to_back();
        logic ack1; logic ack2; int n; logic [DW-1:0] d_q [2]; logic e_q [2];
        tick();
        drive_req(1'b1, 22'h000080, '1, w2);
        #1;
        ack1 = rsp_ack;
        tick();
        drive_req(1'b0, 22'h000080, '0, '0);
        #1;
        ack2 = rsp_ack;
        tick();
        idle();
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            if (rsp_valid) begin
                d_q[n] = rsp_data;
                e_q[n] = rsp_error;
                n++;
            end
            tick();
        end
        checks++; if (ack1 !== 1'b1 || ack2 !== 1'b1) begin failures++; $display("FAIL b2b_ack: got %b%b expected 11", ack1, ack2); end
        checks++; if (n != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", n); end
        checks++; if (n == 2 && (d_q[0] !== '0 || e_q[0] !== 1'b0)) begin failures++; $display("FAIL b2b_wr_rsp: got err=%b data=%h expected err=0 data=0", e_q[0], d_q[0]); end
        checks++; if (n == 2 && d_q[1] !== w2) begin failures++; $display("FAIL b2b_raw: got %h expected %h", d_q[1], w2); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addrs [6];
        int acks;
        addrs[0] = 22'h000000; addrs[1] = 22'h000040; addrs[2] = 22'h000080;
        addrs[3] = 22'h000000; addrs[4] = 22'h000040; addrs[5] = 22'h000080;
        req_rsp_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_req(1'b0, addrs[i], '0, '0);
            #1;
            if (rsp_ack) acks++;
        end
        tick();
        idle();
        #1;
        checks++; if (acks != 4) begin failures++; $display("FAIL bp_acks: got %0d expected 4", acks); end
        checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b expected 0", rsp_ready); end
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== p0) begin failures++; $display("FAIL bp_hold: got v=%b data=%h expected v=1 data=%h", rsp_valid, rsp_data, p0); end
        req_rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL bp_no_passthru: got %b expected 0", rsp_ready); end
        tick();
        checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_retire: got %b expected 1", rsp_ready); end
        checks++; if (rsp_data !== exp1) begin failures++; $display("FAIL bp_order1: got %h expected %h", rsp_data, exp1); end
        tick();
        checks++; if (rsp_data !== w2) begin failures++; $display("FAIL bp_order2: got %h expected %h", rsp_data, w2); end
        tick();
        checks++; if (rsp_data !== p0) begin failures++; $display("FAIL bp_order3: got %h expected %h", rsp_data, p0); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_full_simultaneous();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] exp_q [4];
        int n;
        addrs[0] = 22'h000040; addrs[1] = 22'h000080; addrs[2] = 22'h000000; addrs[3] = 22'h000040;
        exp_q[0] = w2; exp_q[1] = p0; exp_q[2] = exp1; exp_q[3] = p0;
        req_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_req(1'b0, addrs[i], '0, '0);
        end
        tick();
        req_rsp_ready = 1'b1;
        drive_req(1'b0, 22'h000000, '0, '0);
        #1;
        checks++; if (rsp_ack !== 1'b0) begin failures++; $display("FAIL sim_no_ack: got %b expected 0", rsp_ack); end
        checks++; if (rsp_data !== exp1) begin failures++; $display("FAIL sim_head: got %h expected %h", rsp_data, exp1); end
        tick();
        req_rsp_ready = 1'b0;
        #1;
        checks++; if (rsp_ack !== 1'b1) begin failures++; $display("FAIL sim_ack_next: got %b expected 1", rsp_ack); end
        tick();
        idle();
        #1;
        checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL sim_count4: got ready=%b expected 0", rsp_ready); end
        req_rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            if (rsp_valid) begin
                checks++; if (rsp_data !== exp_q[n]) begin failures++; $display("FAIL sim_order%0d: got %h expected %h", n, rsp_data, exp_q[n]); end
                n++;
            end
            tick();
        end
        checks++; if (n != 4) begin failures++; $display("FAIL sim_drain: got %0d expected 4", n); end
    endtask

    task automatic test_reset_mid();
        logic ack; int lat; logic [DW-1:0] rd; logic err;
        int seen; int acks; int n;
        req_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_req(1'b0, 22'h000040, '0, '0);
        end
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_mid_valid: got %0d expected 0", seen); end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            drive_req(1'b0, 22'h000080, '0, '0);
            #1;
            if (rsp_ack) acks++;
            tick();
        end
        idle();
        checks++; if (acks != 4) begin failures++; $display("FAIL rst_mid_outstanding: got %0d acks expected 4", acks); end
        req_rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            if (rsp_valid) n++;
            tick();
        end
        checks++; if (n != 4) begin failures++; $display("FAIL rst_mid_drain: got %0d expected 4", n); end
        run_txn(1'b0, 22'h000080, '0, '0, ack, lat, rd, err);
        checks++; if (ack !== 1'b1 || lat != 2 || rd !== w2 || err !== 1'b0) begin failures++; $display("FAIL rst_mid_read: got ack=%b lat=%0d err=%b data=%h expected ack=1 lat=2 err=0 data=%h", ack, lat, err, rd, w2); end
    endtask

    initial begin
        a5   = {64{8'hA5}};
        ones = '1;
        p0   = {16{32'hDEADBEEF}};
        exp1 = '0;
        exp1[15:0] = 16'hFFFF;
        w2   = {8{64'h0123456789ABCDEF}};
        top  = {16{32'h5A5A1234}};
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_full_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
